state_sel_master: RTL and testbench
===================================

# state_sel_master

Parent supervisor for the state-within-state hierarchy. It owns the `state_select` handshake from the driving end: it parks two child sequence-detector FSMs, releases them one at a time, and waits for each child's hand-back on `state_out`. It reports a two-stage match or a timeout to the level above and keeps a saturating count of completed matches. Each child sits in its own slot: the child's `state_select_in` is driven by `sel*_out`, and the child's `state_out` feeds `done*_in`.

## Interface
- `TIMEOUT`, default 16: maximum cycles a child may stay active without handing back (must be ≥ 2).
- `TW`, default 5: timeout counter width; must satisfy 2^TW ≥ TIMEOUT.
- `CW`, default 8: match counter width.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a sequence; sampled only in IDLE.
- `abort` input 1: synchronous abort; return to IDLE.
- `sel1_out` output 1: to child 1's `state_select_in`; 1 parks and resets the child, 0 activates it.
- `done1_in` input 1: child 1's `state_out` (hand-back).
- `sel2_out` output 1: to child 2's `state_select_in`.
- `done2_in` input 1: child 2's `state_out`.
- `busy` output 1: high in RUN1 and RUN2.
- `match` output 1: one-cycle pulse when both children complete.
- `fail` output 1: one-cycle pulse on timeout.
- `match_cnt` output CW: saturating count of `match` pulses.

## Operation
- States: IDLE, RUN1, RUN2, REPORT, FAIL. Encodings live in the package.
- Outputs per state:
  - IDLE: `sel1_out`=1, `sel2_out`=1.
  - RUN1: `sel1_out`=0, `sel2_out`=1.
  - RUN2: `sel1_out`=1, `sel2_out`=0.
  - REPORT and FAIL: both sels = 1.
- All outputs are registered, so a parked child is reset asynchronously on the same edge the state is entered.
- Transitions:
  - IDLE→RUN1 on `start`.
  - RUN1→RUN2 on `done1_in`.
  - RUN2→REPORT on `done2_in`.
  - REPORT→IDLE unconditionally.
  - FAIL→IDLE unconditionally.
  - RUN1 or RUN2 → FAIL when the timer expires.
- A `done*_in` is honoured only while its slot is active (`sel*_out`=0). A parked child drives x on `state_out`; that value must never reach state logic.
- Timer: cleared on entry to RUN1 and RUN2, increments each cycle in those states, and expires when it equals TIMEOUT-1.
- Priority, highest first: reset > `abort` > `done*_in` > timer expiry. If done and expiry occur in the same cycle, the transition proceeds and no fail is reported.
- `abort` takes any state to IDLE on the next edge, parks both children, and produces no `match` or `fail` pulse.
- `match` is high exactly during REPORT and `fail` exactly during FAIL.
- `match_cnt` increments on REPORT entry and saturates at 2^CW−1; it is not cleared by `abort`.
- `start` is ignored outside IDLE. A `start` held high re-launches from IDLE, giving a one-cycle IDLE gap.

## Timing
- Reset values: state IDLE, `sel1_out`=1, `sel2_out`=1, `busy`=0, `match`=0, `fail`=0, `match_cnt`=0, timer 0.
- Deassertion of `rst_n` is synchronised by the system; this block assumes a clean release.
- `start` sampled at edge k: `sel1_out`=0 from edge k. The child first evaluates its input in cycle k→k+1.
- `done1_in` is combinational from the child and sampled at the edge that ends the child's detecting cycle. `sel1_out` rises and `sel2_out` falls on that same edge, with no cycle of overlap.
- Completion latency: `match` is high for the cycle after the edge that samples `done2_in`; IDLE follows one cycle later.
- Timeout: with no done, FAIL is entered at edge (entry + TIMEOUT). `fail` is high for one cycle, then IDLE.
- Both sels are never 0 simultaneously, in any state or transition.

## Structure
- The package `state_sel_pkg` holds the state encodings (3-bit localparams) and the `SEL_PARK`=1 / `SEL_RUN`=0 constants.
- One sub-module, `cycle_timer`:
  - Inputs: `clk`, `rst_n`, `clr`, `en`.
  - Output: `expired`.
  - Parameterised by TIMEOUT and TW.
- The top level holds the FSM, the output registers and `match_cnt`.

## Test plan
- Reset: drive `rst_n`=0 mid-RUN2 → both sels 1, `busy`/`match`/`fail`=0 and `match_cnt`=0 immediately, without waiting for a clock.
- Nominal run: both slots hold "001" detectors. `start`, then `in`=0,0,1, then 0,0,1 → RUN1 for 3 cycles, RUN2 for 3 cycles, one `match` pulse, `match_cnt`=1, IDLE.
- Timeout: `start` with `in` held 1 and TIMEOUT=16 → `fail` pulses exactly 16 cycles after RUN1 entry, `match_cnt` unchanged.
- Boundary: `done1_in` arrives on the cycle the timer expires → RUN2 entered, no `fail`.
- Abort mid-RUN2 → IDLE next edge, both sels 1, no pulse, `match_cnt` preserved. Then force `done2_in`=x while parked → no state change.
- Saturation: CW=2, five complete runs → `match_cnt` reads 3 after the third run and stays 3.

Source files
------------

// File: rtl/state_sel_pkg.sv
// Shared state encodings and slot-select levels for the state-select supervisor.
package state_sel_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN1   = 3'd1;
    localparam logic [2:0] ST_RUN2   = 3'd2;
    localparam logic [2:0] ST_REPORT = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    // A parked child is held in reset; a running child detects.
    localparam logic SEL_PARK = 1'b1;
    localparam logic SEL_RUN  = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_RUN1   = ST_RUN1,
        S_RUN2   = ST_RUN2,
        S_REPORT = ST_REPORT,
        S_FAIL   = ST_FAIL
    } state_t;

endpackage

// File: rtl/state_sel_master_cycle_timer.sv
// Watchdog counter for an active child slot; expires after TIMEOUT cycles of activity.
module cycle_timer #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // Count reaches TIMEOUT-1 after TIMEOUT-1 active edges, so the FSM leaves on edge TIMEOUT.
    assign expired = en && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/state_sel_master.sv
// Supervisor that releases two child detectors one at a time and reports match or timeout.
module state_sel_master
    import state_sel_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          sel1_out,
    input  logic          done1_in,
    output logic          sel2_out,
    input  logic          done2_in,
    output logic          busy,
    output logic          match,
    output logic          fail,
    output logic [CW-1:0] match_cnt
);

    state_t state, state_nxt;
    logic   expired, tmr_clr, tmr_en;
    logic   done1_ok, done2_ok;

    // A parked child drives x; gating on the select keeps it out of the state logic.
    assign done1_ok = (sel1_out == SEL_RUN) && done1_in;
    assign done2_ok = (sel2_out == SEL_RUN) && done2_in;

    assign tmr_en  = (state == S_RUN1) || (state == S_RUN2);
    assign tmr_clr = (state_nxt != state) && ((state_nxt == S_RUN1) || (state_nxt == S_RUN2));

    cycle_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_nxt = S_RUN1;
                S_RUN1: begin
                    if (done1_ok)     state_nxt = S_RUN2;
                    else if (expired) state_nxt = S_FAIL;
                end
                S_RUN2: begin
                    if (done2_ok)     state_nxt = S_REPORT;
                    else if (expired) state_nxt = S_FAIL;
                end
                S_REPORT: state_nxt = S_IDLE;
                S_FAIL:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sel1_out  <= SEL_PARK;
            sel2_out  <= SEL_PARK;
            busy      <= 1'b0;
            match     <= 1'b0;
            fail      <= 1'b0;
            match_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sel1_out <= (state_nxt == S_RUN1) ? SEL_RUN : SEL_PARK;
            sel2_out <= (state_nxt == S_RUN2) ? SEL_RUN : SEL_PARK;
            busy     <= (state_nxt == S_RUN1) || (state_nxt == S_RUN2);
            match    <= (state_nxt == S_REPORT);
            fail     <= (state_nxt == S_FAIL);
            if ((state_nxt == S_REPORT) && (state != S_REPORT) && (match_cnt != {CW{1'b1}}))
                match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_state_sel_master.sv
// Directed plus randomized run-length bench for state_sel_master with a run-level reference model.
module tb_state_sel_master;

    localparam int TMO = 16;

    // Expected {sel1, sel2, busy, match, fail} per phase.
    localparam logic [4:0] F_IDLE   = 5'b11000;
    localparam logic [4:0] F_RUN1   = 5'b01100;
    localparam logic [4:0] F_RUN2   = 5'b10100;
    localparam logic [4:0] F_REPORT = 5'b11010;
    localparam logic [4:0] F_FAIL   = 5'b11001;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, done1_in, done2_in;
    logic       sel1, sel2, busy, match, fail;
    logic [7:0] cnt;
    logic       sel1b, sel2b, busyb, matchb, failb;
    logic [1:0] cnt2;

    int compared   = 0;
    int mismatched = 0;
    int exp_cnt    = 0;

    always #5 clk = ~clk;

    state_sel_master #(.TIMEOUT(TMO), .TW(5), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sel1_out(sel1), .done1_in(done1_in), .sel2_out(sel2), .done2_in(done2_in),
        .busy(busy), .match(match), .fail(fail), .match_cnt(cnt)
    );

    // Same stimulus into a 2-bit counter instance to observe saturation.
    state_sel_master #(.TIMEOUT(TMO), .TW(5), .CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sel1_out(sel1b), .done1_in(done1_in), .sel2_out(sel2b), .done2_in(done2_in),
        .busy(busyb), .match(matchb), .fail(failb), .match_cnt(cnt2)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [4:0] flags);
        logic [7:0] ec8;
        logic [1:0] ec2;
        ec8 = 8'(exp_cnt);
        ec2 = (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
        compared++;
        assert ({sel1, sel2, busy, match, fail} === flags) else begin
            mismatched++;
            $error("FAIL %s flags: got %b want %b", tag, {sel1, sel2, busy, match, fail}, flags);
        end
        compared++;
        assert ({sel1b, sel2b, busyb, matchb, failb} === flags) else begin
            mismatched++;
            $error("FAIL %s sat_flags: got %b want %b", tag, {sel1b, sel2b, busyb, matchb, failb}, flags);
        end
        compared++;
        assert (cnt === ec8) else begin
            mismatched++;
            $error("FAIL %s match_cnt: got %0d want %0d", tag, cnt, ec8);
        end
        compared++;
        assert (cnt2 === ec2) else begin
            mismatched++;
            $error("FAIL %s sat_cnt: got %0d want %0d", tag, cnt2, ec2);
        end
    endtask

    // One launch: child 1 hands back d1 cycles after release, child 2 d2 cycles after its release.
    // A hand-back is honoured iff it arrives no later than TMO cycles into the slot.
    task automatic run(input int d1, input int d2);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= TMO && j <= d1; j++) begin
            chk("run1", F_RUN1);
            done1_in = (j == d1);
            tick();
            done1_in = 1'bx;
        end
        if (d1 > TMO) begin
            chk("fail1", F_FAIL);
            tick();
            chk("idle_f1", F_IDLE);
            return;
        end
        for (int j = 1; j <= TMO && j <= d2; j++) begin
            chk("run2", F_RUN2);
            done2_in = (j == d2);
            tick();
            done2_in = 1'bx;
        end
        if (d2 > TMO) begin
            chk("fail2", F_FAIL);
            tick();
            chk("idle_f2", F_IDLE);
            return;
        end
        exp_cnt++;
        chk("report", F_REPORT);
        tick();
        chk("idle_ok", F_IDLE);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        done1_in = 1'bx; done2_in = 1'bx;
        tick();
        chk("reset", F_IDLE);
        rst_n = 1'b1;
        tick();
        chk("idle_start", F_IDLE);

        run(3, 3);            // nominal "001" detectors in both slots
        run(TMO, 2);          // done1 on the expiry cycle
        run(2, TMO);          // done2 on the expiry cycle
        run(TMO + 1, 0);      // child 1 never hands back
        run(4, TMO + 1);      // child 2 never hands back
        run(1, 1);

        // Abort mid-RUN2, then a parked child's output must be ignored.
        start = 1'b1; tick(); start = 1'b0;
        done1_in = 1'b0; tick(); done1_in = 1'b1; tick(); done1_in = 1'bx;
        chk("ab_run2", F_RUN2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort", F_IDLE);
        done2_in = 1'bx; tick();
        chk("parked_x", F_IDLE);
        done2_in = 1'b1; tick();
        chk("parked_one", F_IDLE);
        done2_in = 1'bx;

        for (int r = 0; r < 10; r++)
            run(int'($urandom_range(1, TMO + 2)), int'($urandom_range(1, TMO + 2)));

        // Asynchronous reset mid-RUN2, observed without a clock edge.
        start = 1'b1; tick(); start = 1'b0;
        done1_in = 1'b1; tick(); done1_in = 1'bx; done2_in = 1'b0;
        chk("pre_reset", F_RUN2);
        exp_cnt = 0;
        #2 rst_n = 1'b0;
        #1 chk("async_reset", F_IDLE);
        tick();
        rst_n = 1'b1;
        done2_in = 1'bx;
        tick();
        chk("post_reset", F_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
